// File: rtl/nios2_sp_ramp_ctrl_if.sv
// rtl/nios2_sp_ramp_ctrl_if.sv - Avalon-MM register port for the setpoint ramp controller
// Zero wait-state, zero read-latency slave bus: readdata is combinational from address.
interface nios2_sp_ramp_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/nios2_sp_ramp_ctrl.sv
// rtl/nios2_sp_ramp_ctrl.sv - slew-limited setpoint sequencer with Avalon-MM registers and done IRQ
// out_port moves toward TARGET by at most STEP every PRESC+1 clocks; irq = done & irq_en.
module nios2_sp_ramp_ctrl #(
  parameter int                DATA_W    = 20,
  parameter int                PRESC_W   = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  nios2_sp_ramp_ctrl_if.slave   bus,
  output logic [DATA_W-1:0]     out_port,
  output logic                  irq
);

  typedef enum logic {IDLE, RAMP} state_e;

  state_e               state_q;
  logic [DATA_W-1:0]    out_q, target_q, step_q;
  logic [PRESC_W-1:0]   presc_q, cnt_q;
  logic                 irq_en_q, done_q;

  logic                 wr, wr_target, wr_step, wr_presc, wr_ctrl, wr_status;
  logic                 abort, tick, reach;
  logic [DATA_W:0]      diff, mag;
  logic [DATA_W-1:0]    out_d;
  logic [31:0]          rdata;
  logic                 unused_wdata;

  assign wr        = bus.chipselect & ~bus.write_n;
  assign wr_target = wr && (bus.address == 3'd0);
  assign wr_step   = wr && (bus.address == 3'd1);
  assign wr_presc  = wr && (bus.address == 3'd2);
  assign wr_ctrl   = wr && (bus.address == 3'd3);
  assign wr_status = wr && (bus.address == 3'd4);
  assign abort     = wr_ctrl && bus.writedata[1];
  assign unused_wdata = ^bus.writedata[31:DATA_W];

  // STEP==0 skips the prescaler; ">=" guards against PRESC being lowered below the running count
  assign tick  = (state_q == RAMP) && ((step_q == '0) || (cnt_q >= presc_q));
  assign diff  = {1'b0, target_q} - {1'b0, out_q};
  assign mag   = diff[DATA_W] ? (~diff + 1'b1) : diff;
  assign reach = (step_q == '0) || (mag <= {1'b0, step_q});

  always_comb begin
    out_d = target_q;
    if (!reach) out_d = diff[DATA_W] ? (out_q - step_q) : (out_q + step_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      out_q    <= RESET_VAL;
      target_q <= RESET_VAL;
      step_q   <= '0;
      presc_q  <= '0;
      cnt_q    <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (wr_target) target_q <= bus.writedata[DATA_W-1:0];
      if (wr_step)   step_q   <= bus.writedata[DATA_W-1:0];
      if (wr_presc)  presc_q  <= bus.writedata[PRESC_W-1:0];
      if (wr_ctrl)   irq_en_q <= bus.writedata[0];
      if (wr_status && bus.writedata[1]) done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (wr_target) begin
            state_q <= RAMP;
            cnt_q   <= '0;
            done_q  <= 1'b0;
          end
        end
        RAMP: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (tick) begin
            out_q <= out_d;
            cnt_q <= '0;
            if (reach) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + PRESC_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.address)
      3'd0:    rdata[DATA_W-1:0]  = target_q;
      3'd1:    rdata[DATA_W-1:0]  = step_q;
      3'd2:    rdata[PRESC_W-1:0] = presc_q;
      3'd3:    rdata[0]           = irq_en_q;
      3'd4:    rdata[1:0]         = {done_q, state_q == RAMP};
      3'd5:    rdata[DATA_W-1:0]  = out_q;
      default: rdata = '0;
    endcase
  end

  assign bus.readdata = rdata;
  assign out_port     = out_q;
  assign irq          = done_q & irq_en_q;

endmodule
